// File: rtl/uart_tx_sched_if.sv
// Byte-source handshake and UartTx drive signals shared by uart_tx_sched.
// slave: the scheduler. master: the byte producers together with UartTx.
interface uart_tx_sched_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_data;
    logic              tx_latch;
    logic              tx_busy;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_latch
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_latch
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UartTx between NREQ byte sources.
// Optional message lock: define UART_SCHED_LOCK_EN to keep the arbiter on one
// source until it sends a byte marked req_last.
module uart_tx_sched #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic            clk,
    input  logic            nrst,
    uart_tx_sched_if.slave  bus,
    output logic [NREQ-1:0] grant,
    input  logic            err_clr,
    output logic            timeout_err
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(ACK_TIMEOUT);
    localparam logic [PW-1:0] PTR_RST  = PW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        ACK_WAIT,
        DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_latch_q, tx_latch_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout_err_q, timeout_err_d;
    logic            timeout_set;

`ifdef UART_SCHED_LOCK_EN
    logic            lock_q, lock_d;
    logic [PW-1:0]   lock_idx_q, lock_idx_d;
`else
    logic            last_unused;
    assign last_unused = ^bus.req_last;
`endif

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] win_oh;
    logic [7:0]      win_data;
    logic [PW-1:0]   cand;
    logic            allowed;
    logic [NREQ-1:0] ready;
    logic            transfer;

    // Round-robin winner: first valid (and permitted) source after ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        win_data  = '0;
        cand      = '0;
        allowed   = 1'b0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = PW'((32'(ptr_q) + off) % NREQ);
`ifdef UART_SCHED_LOCK_EN
            allowed = !lock_q || (cand == lock_idx_q);
`else
            allowed = 1'b1;
`endif
            if (!win_found && bus.req_valid[cand] && allowed) begin
                win_found     = 1'b1;
                win_idx       = cand;
                win_oh[cand]  = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_data = bus.req_data[8*i +: 8];
            end
        end
    end

    // Ready is offered only from IDLE while UartTx is free; held low in reset.
    always_comb begin
        ready = '0;
        if (nrst && (state_q == IDLE) && !bus.tx_busy && win_found) begin
            ready = win_oh;
        end
        transfer = |(bus.req_valid & ready);
    end

    // Next-state and registered-output computation for the launch FSM.
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_latch_d  = 1'b0;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        timeout_set = 1'b0;
`ifdef UART_SCHED_LOCK_EN
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    tx_data_d  = win_data;
                    tx_latch_d = 1'b1;
                    grant_d    = win_oh;
                    state_d    = LAUNCH;
`ifdef UART_SCHED_LOCK_EN
                    // ptr only advances when a message ends, so the locked
                    // source does not skew the rotation of the others.
                    if (bus.req_last[win_idx]) begin
                        lock_d = 1'b0;
                        ptr_d  = win_idx;
                    end else begin
                        lock_d     = 1'b1;
                        lock_idx_d = win_idx;
                    end
`else
                    ptr_d = win_idx;
`endif
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = ACK_WAIT;
            end
            ACK_WAIT: begin
                if (bus.tx_busy) begin
                    state_d = DRAIN;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_set = 1'b1;
                    grant_d     = '0;
                    state_d     = IDLE;
`ifdef UART_SCHED_LOCK_EN
                    if (lock_q) begin
                        ptr_d = lock_idx_q;
                    end
                    lock_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (!bus.tx_busy) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
        // A timeout in the same cycle as err_clr wins.
        timeout_err_d = timeout_set ? 1'b1 : (err_clr ? 1'b0 : timeout_err_q);
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= IDLE;
            tx_data_q     <= '0;
            tx_latch_q    <= 1'b0;
            grant_q       <= '0;
            ptr_q         <= PTR_RST;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`ifdef UART_SCHED_LOCK_EN
            lock_q        <= 1'b0;
            lock_idx_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_latch_q    <= tx_latch_d;
            grant_q       <= grant_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
`ifdef UART_SCHED_LOCK_EN
            lock_q        <= lock_d;
            lock_idx_q    <= lock_idx_d;
`endif
        end
    end

    assign bus.req_ready = ready;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_latch  = tx_latch_q;
    assign grant         = grant_q;
    assign timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a behavioural UartTx and a
// transaction-level arbitration model. Honours UART_SCHED_LOCK_EN if defined.
module tb_uart_tx_sched;
    localparam int unsigned NREQ        = 4;
    localparam int unsigned ACK_TIMEOUT = 4;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic            err_clr = 1'b0;
    logic [NREQ-1:0] grant;
    logic            timeout_err;

    uart_tx_sched_if #(.NREQ(NREQ)) bus ();

    uart_tx_sched #(.NREQ(NREQ), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .bus         (bus),
        .grant       (grant),
        .err_clr     (err_clr),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Behavioural UartTx: busy rises on the edge that sees latch, holds 'hold' cycles.
    logic        uart_busy = 1'b0;
    logic        ext_busy  = 1'b0;
    int unsigned uart_left = 0;
    bit          respond   = 1'b1;
    int unsigned hold      = 12;
    assign bus.tx_busy = uart_busy | ext_busy;

    always @(posedge clk) begin
        if (bus.tx_latch && respond) begin
            uart_busy <= 1'b1;
            uart_left <= hold;
        end else if (uart_left != 0) begin
            uart_left <= uart_left - 1;
            if (uart_left == 1) uart_busy <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arbitration reference: last served source, plus message lock.
    int m_last     = NREQ - 1;
    bit m_lock     = 1'b0;
    int m_lock_idx = 0;

    function automatic int exp_winner(input logic [NREQ-1:0] mask);
        if (m_lock) return mask[m_lock_idx] ? m_lock_idx : -1;
        for (int off = 1; off <= NREQ; off++) begin
            if (mask[(m_last + off) % NREQ]) return (m_last + off) % NREQ;
        end
        return -1;
    endfunction

    function automatic void model_take(input int w, input logic last);
`ifdef UART_SCHED_LOCK_EN
        if (last) begin
            m_lock = 1'b0;
            m_last = w;
        end else begin
            m_lock     = 1'b1;
            m_lock_idx = w;
        end
`else
        if (last || !last) m_last = w;
`endif
    endfunction

    function automatic void model_timeout();
        if (m_lock) m_last = m_lock_idx;
        m_lock = 1'b0;
    endfunction

    function automatic void model_reset();
        m_last = NREQ - 1;
        m_lock = 1'b0;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int w);
        logic [NREQ-1:0] r;
        r = '0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] g);
        int n;
        int idx;
        n = 0;
        idx = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (g[i] === 1'b1) begin
                n++;
                idx = i;
            end
        end
        return (n == 1) ? idx : -1;
    endfunction

    function automatic logic [8*NREQ-1:0] rand_data();
        logic [8*NREQ-1:0] d;
        for (int i = 0; i < NREQ; i++) d[8*i +: 8] = 8'($urandom);
        return d;
    endfunction

    // Offer bytes, check ready/latch/data/grant; returns at the ACK_WAIT entry cycle.
    task automatic launch(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] last,
                          input bit keep, input logic [8*NREQ-1:0] data,
                          output int g, output int w);
        bus.req_data  = data;
        bus.req_last  = last;
        bus.req_valid = mask;
        #1;
        w = exp_winner(mask);
        g = -1;
        check("req_ready", bus.req_ready, onehot(w));
        if (w < 0) return;
        @(posedge clk); #1;
        check("ready_after_take", bus.req_ready, '0);
        if (!keep) bus.req_valid = '0;
        model_take(w, last[w]);
        g = oh_idx(grant);
        check("tx_latch_on", bus.tx_latch, 1);
        check("tx_data", bus.tx_data, data[8*w +: 8]);
        check("grant", grant, onehot(w));
        @(posedge clk); #1;
        check("tx_latch_off", bus.tx_latch, 0);
        check("grant_hold", grant, onehot(w));
    endtask

    // Grant must drop exactly one cycle after busy falls.
    task automatic wait_release();
        int unsigned budget = 200;
        int unsigned lag = 0;
        while (grant != '0 && budget != 0) begin
            if (!bus.tx_busy) lag++;
            @(posedge clk); #1;
            budget--;
        end
        check("grant_release", grant, '0);
        check("release_lag", lag, 1);
    endtask

    task automatic timeout_frame(input logic [NREQ-1:0] mask, input bit clr_held);
        int g;
        int w;
        respond = 1'b0;
        err_clr = clr_held;
        launch(mask, '1, 1'b0, rand_data(), g, w);
        for (int c = 2; c <= ACK_TIMEOUT + 1; c++) begin
            @(posedge clk); #1;
            if (c <= ACK_TIMEOUT) check("err_early", timeout_err, 0);
        end
        check("err_set", timeout_err, 1);
        check("grant_drop", grant, '0);
        model_timeout();
        respond = 1'b1;
    endtask

    task automatic pulse_reset();
        nrst = 1'b0;
        #2;
        nrst = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int w;
        int seq[5];
        int rem2;
        logic [8*NREQ-1:0] d;
        logic [NREQ-1:0] mask;
        logic [NREQ-1:0] last;
        int unsigned budget;

        // Reset values, with sources valid so ready gating is exercised.
        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.req_last  = '1;
        #2;
        check("rst_ready", bus.req_ready, '0);
        check("rst_grant", grant, '0);
        check("rst_latch", bus.tx_latch, 0);
        check("rst_data", bus.tx_data, 0);
        check("rst_err", timeout_err, 0);
        bus.req_valid = '0;
        #10 nrst = 1'b1;
        @(posedge clk); #1;

        // Single source 0, byte 0x51, UartTx busy for 12 cycles.
        d = rand_data();
        d[7:0] = 8'h51;
        hold = 12;
        launch(4'b0001, '1, 1'b0, d, g, w);
        check("t1_grant_src", g, 0);
        wait_release();

        // External busy blocks ready; source 1 granted as soon as it drops.
        ext_busy = 1'b1;
        bus.req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("ext_busy_ready", bus.req_ready, '0);
            check("ext_busy_grant", grant, '0);
        end
        ext_busy = 1'b0;
        launch(4'b0010, '1, 1'b0, rand_data(), g, w);
        check("ext_busy_src", g, 1);
        wait_release();

        // All four valid continuously after reset: rotation 0,1,2,3,0.
        pulse_reset();
        @(posedge clk); #1;
        for (int f = 0; f < 5; f++) begin
            hold = $urandom_range(1, 6);
            launch(4'b1111, '1, 1'b1, rand_data(), g, w);
            wait_release();
            seq[f] = g;
        end
        bus.req_valid = '0;
        check("rr_order0", seq[0], 0);
        check("rr_order1", seq[1], 1);
        check("rr_order2", seq[2], 2);
        check("rr_order3", seq[3], 3);
        check("rr_order4", seq[4], 0);

        // Source 2 sends a 3-byte message while source 0 stays valid.
        hold = 3;
        launch(4'b0010, '1, 1'b0, rand_data(), g, w);
        wait_release();
        rem2 = 3;
        for (int f = 0; f < 4; f++) begin
            mask = 4'b0001;
            last = 4'b1011;
            if (rem2 != 0) mask[2] = 1'b1;
            if (rem2 == 1) last[2] = 1'b1;
            launch(mask, last, 1'b0, rand_data(), g, w);
            wait_release();
            seq[f] = g;
            if (w == 2) rem2--;
`ifdef UART_SCHED_LOCK_EN
            if (f == 0) begin
                bus.req_valid = 4'b0001;
                #1;
                check("lock_blocks_other", bus.req_ready, '0);
                bus.req_valid = '0;
            end
`endif
        end
`ifdef UART_SCHED_LOCK_EN
        check("lock_seq0", seq[0], 2);
        check("lock_seq1", seq[1], 2);
        check("lock_seq2", seq[2], 2);
        check("lock_seq3", seq[3], 0);
`else
        check("nolock_seq0", seq[0], 2);
        check("nolock_seq1", seq[1], 0);
        check("nolock_seq2", seq[2], 2);
        check("nolock_seq3", seq[3], 0);
`endif

        // UartTx never answers: timeout, back in IDLE, sticky until err_clr.
        timeout_frame(4'b0100, 1'b0);
        bus.req_valid = 4'b0001;
        #1;
        check("idle_after_timeout", bus.req_ready, onehot(exp_winner(4'b0001)));
        bus.req_valid = '0;
        @(posedge clk); #1;
        check("err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        check("err_cleared", timeout_err, 0);
        err_clr = 1'b0;

        // err_clr held through a timeout: the set wins that cycle.
        timeout_frame(4'b1000, 1'b1);
        @(posedge clk); #1;
        check("err_clr_after", timeout_err, 0);
        err_clr = 1'b0;

        // Reset during DRAIN: async return to reset values, source 0 next.
        hold = 12;
        launch(4'b0100, '1, 1'b0, rand_data(), g, w);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("drain_busy", bus.tx_busy, 1);
        bus.req_valid = '1;
        nrst = 1'b0;
        #1;
        check("mid_rst_grant", grant, '0);
        check("mid_rst_latch", bus.tx_latch, 0);
        check("mid_rst_data", bus.tx_data, 0);
        check("mid_rst_ready", bus.req_ready, '0);
        check("mid_rst_err", timeout_err, 0);
        bus.req_valid = '0;
        #2;
        nrst = 1'b1;
        model_reset();
        budget = 100;
        while (bus.tx_busy && budget != 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check("uart_finished", bus.tx_busy, 0);
        launch(4'b1111, '1, 1'b0, rand_data(), g, w);
        check("post_rst_src", g, 0);
        wait_release();

        // Randomised masks, data and busy lengths against the model.
        for (int f = 0; f < 24; f++) begin
            hold = $urandom_range(1, 6);
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            launch(mask, '1, 1'b0, rand_data(), g, w);
            check("rand_src", g, w);
            wait_release();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
